// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock/forwarding controller with an EX..WB destination scoreboard.
// Define PIPE_HAZARD_CTRL_FWD_EN to build operand forwarding (load-use interlock only).
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FSW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [FSW-1:0]    fwd_a_sel,
  output logic [FSW-1:0]    fwd_b_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } sb_t;
`else
  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
  } sb_t;
`endif

  sb_t  sb_p0 [DEPTH];
  sb_t  sb_in;
  logic haz;

  function automatic logic src_match(input logic en, input logic [REG_AW-1:0] r, input sb_t e);
    return en && (r != '0) && e.v && e.wr && (e.rd == r);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
  endfunction

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  logic [FSW-1:0] sel_a, sel_b;

  // Scanning oldest to youngest lets the youngest match overwrite the select.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (src_match(id_rs_en, id_rs, sb_p0[k])) sel_a = FSW'(k + 1);
      if (src_match(id_rt_en, id_rt, sb_p0[k])) sel_b = FSW'(k + 1);
    end
    haz = sb_p0[0].ld &&
          (src_match(id_rs_en, id_rs, sb_p0[0]) || src_match(id_rt_en, id_rt, sb_p0[0]));
  end

  assign fwd_a_sel = rst ? sel_a : '0;
  assign fwd_b_sel = rst ? sel_b : '0;
  assign sb_in     = bubble ? '0 : '{v: 1'b1, wr: id_wr_en, rd: id_rd, ld: id_is_load};
`else
  logic unused_ld;

  // WB (entry DEPTH-1) is excluded: the register file is write-before-read.
  always_comb begin
    haz = 1'b0;
    for (int k = 0; k <= DEPTH - 2; k++) begin
      if (src_match(id_rs_en, id_rs, sb_p0[k]) || src_match(id_rt_en, id_rt, sb_p0[k]))
        haz = 1'b1;
    end
  end

  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
  assign unused_ld = id_is_load;
  assign sb_in     = bubble ? '0 : '{v: 1'b1, wr: id_wr_en, rd: id_rd};
`endif

  // A taken branch overrides the interlock; reset forces both low at once.
  assign flush  = ex_br_taken & rst;
  assign stall  = id_valid & haz & ~ex_br_taken & rst;
  assign bubble = stall | flush | ~id_valid;

  // Scoreboard shift EX -> WB and saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) sb_p0[k] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb_p0[0] <= sb_in;
      for (int k = 1; k < DEPTH; k++) sb_p0[k] <= sb_p0[k-1];
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (DEPTH=3, REG_AW=5); follows PIPE_HAZARD_CTRL_FWD_EN when defined.
module tb_pipe_hazard_ctrl;
  localparam int DEPTH = 3;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst;
  logic        id_valid, id_rs_en, id_rt_en, id_wr_en, id_is_load, ex_br_taken;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, bubble, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(stall), .bubble(bubble),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: every issued instruction with the cycle it issued in; age = stage index.
  typedef struct {int c; bit wr; bit [4:0] rd; bit ld;} rec_t;
  rec_t hist[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  logic [31:0] m_scnt = 0, m_fcnt = 0;
  logic e_stall, e_flush, e_bubble;
  logic [1:0] e_fa, e_fb;
  logic o_stall, o_flush, o_bubble;
  logic [1:0] o_fa, o_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest in-flight writer of r that still hazards/forwards (age 0..DEPTH-2), -1 if none.
  function automatic int youngest(input bit en, input bit [4:0] r);
    int best = -1;
    if (!en || r == 0) return -1;
    foreach (hist[i]) begin
      int a = cyc - hist[i].c - 1;
      if (hist[i].wr && hist[i].rd == r && a >= 0 && a <= DEPTH - 2 && (best < 0 || a < best))
        best = a;
    end
    return best;
  endfunction

  function automatic bit ex_is_load();
    foreach (hist[i]) if (cyc - hist[i].c - 1 == 0 && hist[i].ld) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_cycle();
    int aa, ab;
    bit haz;
    #1;
    aa = youngest(id_rs_en, id_rs);
    ab = youngest(id_rt_en, id_rt);
    if (FWD) begin
      haz  = ex_is_load() && (aa == 0 || ab == 0);
      e_fa = (aa < 0) ? 2'd0 : 2'(aa + 1);
      e_fb = (ab < 0) ? 2'd0 : 2'(ab + 1);
    end else begin
      haz  = (aa >= 0) || (ab >= 0);
      e_fa = 2'd0;
      e_fb = 2'd0;
    end
    e_stall  = id_valid && haz && !ex_br_taken;
    e_flush  = ex_br_taken;
    e_bubble = e_stall || e_flush || !id_valid;
    o_stall = stall; o_flush = flush; o_bubble = bubble; o_fa = fwd_a_sel; o_fb = fwd_b_sel;
    chk("stall", stall, e_stall);
    chk("flush", flush, e_flush);
    chk("bubble", bubble, e_bubble);
    chk("fwd_a_sel", fwd_a_sel, e_fa);
    chk("fwd_b_sel", fwd_b_sel, e_fb);
    @(posedge clk);
    #1;
    if (!e_bubble) hist.push_back('{cyc, id_wr_en, id_rd, id_is_load});
    cyc++;
    if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (e_flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    while (hist.size() > 0 && cyc - hist[0].c - 1 > DEPTH - 1) void'(hist.pop_front());
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
  endtask

  task automatic drive(input bit v, input bit rse, input int rs, input bit rte, input int rt,
                       input bit wr, input int rd, input bit ld, input bit br);
    @(negedge clk);
    id_valid = v; id_rs_en = rse; id_rs = rs[4:0]; id_rt_en = rte; id_rt = rt[4:0];
    id_wr_en = wr; id_rd = rd[4:0]; id_is_load = ld; ex_br_taken = br;
  endtask

  task automatic step(input bit v, input bit rse, input int rs, input bit rte, input int rt,
                      input bit wr, input int rd, input bit ld, input bit br);
    drive(v, rse, rs, rte, rt, wr, rd, ld, br);
    do_cycle();
  endtask

  task automatic writer(input int rd, input bit ld);
    step(1, 0, 0, 0, 0, 1, rd, ld, 0);
  endtask
  task automatic read_a(input int r);
    step(1, 1, r, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic read_b(input int r);
    step(1, 0, 0, 1, r, 0, 0, 0, 0);
  endtask
  task automatic drain();
    repeat (DEPTH) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse of half a cycle with a hazarding r5 reader and a taken branch in flight.
  task automatic reset_pulse();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    #1;
    hist.delete();
    m_scnt = 0;
    m_fcnt = 0;
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_bubble", bubble, 1'b0);
    chk("rst_fwd_a", fwd_a_sel, 2'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    ex_br_taken = 1'b0;
    #2;
    rst = 1'b1;
    do_cycle();
    chk("post_rst_issue", o_stall, 1'b0);
  endtask

  logic [31:0] base;

  initial begin
    rst = 1'b0;
    id_valid = 0; id_rs_en = 0; id_rt_en = 0; id_rs = 0; id_rt = 0;
    id_wr_en = 0; id_rd = 0; id_is_load = 0; ex_br_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_stall_cnt", stall_cnt, 32'd0);
    chk("init_flush_cnt", flush_cnt, 32'd0);
    chk("init_bubble", bubble, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Reset clears three r5 writers and the counters
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("pre_rst_flush_cnt", flush_cnt, 32'd1);
    writer(5, 0); writer(5, 0); writer(5, 0);
    reset_pulse();
    drain();

    // Back-to-back RAW on rs
    base = m_scnt;
    writer(5, 0);
    read_a(5);
    chk("raw_stall", o_stall, FWD ? 1'b0 : 1'b1);
    chk("raw_fwd_a", o_fa, FWD ? 2'd1 : 2'd0);
    read_a(5);
    read_a(5);
    chk("raw_issue", o_stall, 1'b0);
    chk("raw_stall_cnt", stall_cnt, base + (FWD ? 32'd0 : 32'd2));
    drain();

    // One unrelated instruction in between
    writer(5, 0);
    writer(10, 0);
    read_a(5);
    chk("gap_stall", o_stall, FWD ? 1'b0 : 1'b1);
    chk("gap_fwd_a", o_fa, FWD ? 2'd2 : 2'd0);
    read_a(5);
    drain();

    // Load-use on rt
    base = m_scnt;
    writer(7, 1);
    read_b(7);
    chk("lu_stall1", o_stall, 1'b1);
    read_b(7);
    chk("lu_stall2", o_stall, FWD ? 1'b0 : 1'b1);
    chk("lu_fwd_b", o_fb, FWD ? 2'd2 : 2'd0);
    read_b(7);
    chk("lu_stall_cnt", stall_cnt, base + (FWD ? 32'd1 : 32'd2));
    drain();

    // r0 never hazards
    writer(0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("r0_stall", o_stall, 1'b0);
    chk("r0_fwd_a", o_fa, 2'd0);
    chk("r0_fwd_b", o_fb, 2'd0);
    drain();

    // Youngest writer wins
    writer(3, 0);
    writer(3, 0);
    read_b(3);
    chk("prio_stall", o_stall, FWD ? 1'b0 : 1'b1);
    chk("prio_fwd_b", o_fb, FWD ? 2'd1 : 2'd0);
    read_b(3);
    read_b(3);
    drain();

    // Taken branch while load-use pending
    base = m_fcnt;
    writer(9, 1);
    step(1, 0, 0, 1, 9, 0, 0, 0, 1);
    chk("br_stall", o_stall, 1'b0);
    chk("br_flush", o_flush, 1'b1);
    chk("br_bubble", o_bubble, 1'b1);
    chk("br_flush_cnt", flush_cnt, base + 32'd1);
    read_b(9);
    chk("br_ex_empty", o_stall, FWD ? 1'b0 : 1'b1);
    drain();

    // Random traffic on a small register set
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(7) != 0, $urandom_range(1), $urandom_range(3),
             $urandom_range(1), $urandom_range(3), $urandom_range(1),
             $urandom_range(3), $urandom_range(2) == 0, $urandom_range(9) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline interlock and forwarding controller for the multi-segment CPU family. It sits beside the IF/ID/EX/MEM/WB segment registers and tracks every issued instruction's destination register in a scoreboard shift register from EX to WB. Each cycle it decides whether the instruction in ID may issue, must stall, or is squashed by a taken branch. Pipeline depth and register-address width are generic, and operand forwarding can be compiled in or out.

## Interface
Parameters:
- REG_AW, 5, register-address width (2^REG_AW architectural registers; register 0 is hard-wired zero).
- DEPTH, 3, number of tracked in-flight stages after ID (stage 0 = EX … stage DEPTH-1 = WB). Legal range 2..8.
- FSW, $clog2(DEPTH), width of the forward-select outputs.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction; 0 = bubble.
- id_rs_en, id_rt_en  in  1 each  source A and source B are read.
- id_rs, id_rt  in  REG_AW each  source register numbers.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  REG_AW  destination register.
- id_is_load  in  1  the result is produced in MEM, not EX.
- ex_br_taken  in  1  the branch in EX resolved taken this cycle.
- stall  out  1  hold PC and the IF/ID register this cycle.
- bubble  out  1  issue a NOP into EX instead of the ID instruction.
- flush  out  1  squash the IF and ID contents.
- fwd_a_sel, fwd_b_sel  out  FSW each  operand source: 0 = register file, k+1 = result of scoreboard stage k.
- stall_cnt, flush_cnt  out  32 each  saturating performance counters.

## Operation
- Scoreboard entry k holds {v, wr, rd, ld}. On every clock edge, entry k+1 takes entry k, and the entry at DEPTH-1 is discarded.
- Entry 0 takes {id_valid, id_wr_en, id_rd, id_is_load} when the instruction issues. It takes all-zero when bubble=1.
- A source *matches* entry k when its enable is 1, its register number is non-zero, and it equals rd with v=1 and wr=1.
- WB (entry DEPTH-1) never causes a hazard. The register file writes in the first half-cycle and is read in the second.
- Without forwarding: hazard = any source matches any entry 0..DEPTH-2. Both fwd_*_sel are held at 0.
- With forwarding:
  - Hazard = a source matches entry 0 and that entry has ld=1 (load-use).
  - Otherwise fwd_*_sel = k+1 for the lowest matching k in 0..DEPTH-2, or 0 if there is no match.
  - If several entries match, the youngest entry (lowest k) wins.
- Output equations:
  - stall = id_valid & hazard & ~ex_br_taken
  - flush = ex_br_taken
  - bubble = stall | flush | ~id_valid
- Simultaneous branch and hazard: flush wins. Stall is 0, and the ID instruction is squashed, not held.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- stall, bubble, flush and fwd_*_sel are combinational from the ID inputs, ex_br_taken and the registered scoreboard. They are valid in the same cycle, with zero latency.
- The scoreboard and counters update on the rising clk edge.
- rst low asynchronously clears:
  - every scoreboard entry to all-zero;
  - both counters to 0.
- While rst is low, the outputs are:
  - stall=0 and flush=0;
  - bubble = ~id_valid;
  - fwd_*_sel=0.
- Reset mid-stall drops the interlock immediately.
- A RAW stall without forwarding lasts at most DEPTH-1 cycles. A load-use stall with forwarding lasts exactly 1 cycle.

## Configuration
- PIPE_HAZARD_CTRL_FWD_EN defined:
  - forwarding paths and fwd_*_sel logic are generated;
  - the only interlock is load-use.
- PIPE_HAZARD_CTRL_FWD_EN undefined:
  - the ld field and the forwarding muxes are removed;
  - fwd_*_sel are tied to 0;
  - full RAW interlock applies.

## Test plan
- Reset: load the scoreboard with three writers to r5, then pulse rst low for half a cycle. Required: the scoreboard empties immediately, stall=0, both counters read 0, and an r5 reader issues with no stall.
- No-fwd RAW (DEPTH=3): issue "write r5", then immediately "read r5 as rs". Required: stall=1 for exactly 2 cycles, the reader then issues, and stall_cnt=2.
- Fwd RAW (DEPTH=3, FWD_EN): same sequence. Required: stall=0 and fwd_a_sel=1. With one unrelated instruction between them, fwd_a_sel=2.
- Fwd load-use: issue "load r7", then "read r7 as rt". Required: stall=1 for 1 cycle, then fwd_b_sel=2, and stall_cnt=1.
- r0 and priority: a writer to r0 followed by a reader of r0 gives no stall and sel=0. Writers to r3 at entries 0 and 1 with a reader of r3 give sel=1.
- Branch during stall: a load-use hazard pending while ex_br_taken=1 gives flush=1, stall=0 and bubble=1. Required: flush_cnt increments by 1 and entry 0 is invalid on the next cycle.
